// File: rtl/ravenoc_pkg.sv
// Shared flit types and widths for the NoC network-interface transmit path.
// The head flit layout is {type, x_dest, y_dest, pkt_size, zero pad}.
package ravenoc_pkg;
    localparam int FLIT_WIDTH      = 34;
    localparam int FLIT_DATA_WIDTH = 32;
    localparam int PKT_WIDTH       = 9;
    localparam int X_WIDTH         = 2;
    localparam int Y_WIDTH         = 2;
    localparam int VC_WIDTH        = 2;
    localparam int HEAD_PAD_WIDTH  = FLIT_WIDTH - 2 - X_WIDTH - Y_WIDTH - PKT_WIDTH;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'b01,
        BODY_FLIT = 2'b10,
        TAIL_FLIT = 2'b11
    } flit_type_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } tx_state_t;

    typedef struct packed {
        flit_type_t                 flit_type;
        logic [X_WIDTH-1:0]         x_dest;
        logic [Y_WIDTH-1:0]         y_dest;
        logic [PKT_WIDTH-1:0]       pkt_size;
        logic [HEAD_PAD_WIDTH-1:0]  rsvd;
    } s_flit_head_data_t;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] fdata;
        logic [VC_WIDTH-1:0]   vc_id;
        logic                  valid;
    } s_flit_req_t;

    typedef struct packed {
        logic ready;
    } s_flit_resp_t;
endpackage

// File: rtl/flit_out_reg.sv
// One-entry flit output register. Handshake: a flit transfers on a cycle where
// valid and ready are both high; valid/fdata/vc_id hold until that happens.
module flit_out_reg
    import ravenoc_pkg::*;
(
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  load_i,
    input  logic [FLIT_WIDTH-1:0] fdata_i,
    input  logic [VC_WIDTH-1:0]   vc_i,
    input  logic                  ready_i,
    output logic                  can_load_o,
    output s_flit_req_t           req_o
);
    logic                  valid_q, valid_d;
    logic [FLIT_WIDTH-1:0] fdata_q, fdata_d;
    logic [VC_WIDTH-1:0]   vc_q, vc_d;
    logic                  drain;

    assign drain      = valid_q && ready_i;
    // Loading while the current flit drains keeps one flit per cycle.
    assign can_load_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        fdata_d = fdata_q;
        vc_d    = vc_q;
        if (load_i) begin
            valid_d = 1'b1;
            fdata_d = fdata_i;
            vc_d    = vc_i;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            valid_q <= 1'b0;
            fdata_q <= '0;
            vc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            fdata_q <= fdata_d;
            vc_q    <= vc_d;
        end
    end

    assign req_o.fdata = fdata_q;
    assign req_o.vc_id = vc_q;
    assign req_o.valid = valid_q;
endmodule

// File: rtl/flit_tx_packetizer.sv
// Serializes a packet descriptor plus payload words into head/body/tail flits.
// Optional counters stat_pkts_o/stat_stall_o exist when RAVENOC_TX_STATS_EN is defined.
module flit_tx_packetizer
    import ravenoc_pkg::*;
#(
    parameter int MAX_PKT_FLITS = 256
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       pkt_valid_i,
    output logic                       pkt_ready_o,
    input  logic [VC_WIDTH-1:0]        pkt_vc_i,
    input  logic [X_WIDTH-1:0]         pkt_x_i,
    input  logic [Y_WIDTH-1:0]         pkt_y_i,
    input  logic [PKT_WIDTH-1:0]       pkt_size_i,
    input  logic                       data_valid_i,
    output logic                       data_ready_o,
    input  logic [FLIT_DATA_WIDTH-1:0] data_i,
    output s_flit_req_t                fout_req_o,
    input  s_flit_resp_t               fout_resp_i,
`ifdef RAVENOC_TX_STATS_EN
    output logic [31:0]                stat_pkts_o,
    output logic [31:0]                stat_stall_o,
`endif
    output tx_state_t                  state_o,
    output logic                       busy_o
);
    localparam logic [PKT_WIDTH-1:0] MAX_SIZE = PKT_WIDTH'(MAX_PKT_FLITS);
    localparam logic [PKT_WIDTH-1:0] ONE      = PKT_WIDTH'(1);

    tx_state_t             state_q, state_d;
    logic [PKT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [VC_WIDTH-1:0]   vc_q, vc_d;
    logic [PKT_WIDTH-1:0]  size_clamped;
    logic                  can_load;
    logic                  load;
    logic [FLIT_WIDTH-1:0] load_fdata;
    s_flit_head_data_t     head;

    assign size_clamped = (pkt_size_i > MAX_SIZE) ? MAX_SIZE : pkt_size_i;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        vc_d         = vc_q;
        pkt_ready_o  = 1'b0;
        data_ready_o = 1'b0;
        load         = 1'b0;
        load_fdata   = '0;
        head         = '0;
        case (state_q)
            ST_IDLE: begin
                pkt_ready_o = can_load;
                if (pkt_valid_i && can_load) begin
                    load           = 1'b1;
                    vc_d           = pkt_vc_i;
                    remaining_d    = size_clamped;
                    head.flit_type = HEAD_FLIT;
                    head.x_dest    = pkt_x_i;
                    head.y_dest    = pkt_y_i;
                    head.pkt_size  = size_clamped;
                    load_fdata     = head;
                    if (size_clamped != '0) state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                data_ready_o = can_load;
                if (data_valid_i && can_load && remaining_q != '0) begin
                    load        = 1'b1;
                    remaining_d = remaining_q - ONE;
                    load_fdata[FLIT_WIDTH-1 -: 2] = (remaining_q == ONE) ? TAIL_FLIT : BODY_FLIT;
                    load_fdata[FLIT_DATA_WIDTH-1:0] = data_i;
                    if (remaining_q == ONE) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            vc_q        <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            vc_q        <= vc_d;
        end
    end

    // vc_d carries the new VC on a head load and the held VC otherwise.
    flit_out_reg u_out_reg (
        .clk       (clk),
        .arst      (arst),
        .load_i    (load),
        .fdata_i   (load_fdata),
        .vc_i      (vc_d),
        .ready_i   (fout_resp_i.ready),
        .can_load_o(can_load),
        .req_o     (fout_req_o)
    );

    assign state_o = state_q;
    assign busy_o  = (state_q != ST_IDLE) || fout_req_o.valid;

`ifdef RAVENOC_TX_STATS_EN
    s_flit_head_data_t out_head;
    logic              pkt_done;
    logic              stall;
    logic [31:0]       stat_pkts_q, stat_stall_q;

    assign out_head = s_flit_head_data_t'(fout_req_o.fdata);
    assign pkt_done = fout_req_o.valid && fout_resp_i.ready &&
                      ((out_head.flit_type == TAIL_FLIT) ||
                       (out_head.flit_type == HEAD_FLIT && out_head.pkt_size == '0));
    assign stall    = fout_req_o.valid && !fout_resp_i.ready;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            stat_pkts_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            if (pkt_done && stat_pkts_q != 32'hFFFF_FFFF) stat_pkts_q <= stat_pkts_q + 32'd1;
            if (stall && stat_stall_q != 32'hFFFF_FFFF) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_pkts_o  = stat_pkts_q;
    assign stat_stall_o = stat_stall_q;
`endif
endmodule

// File: doc/flit_tx_packetizer.md
# flit_tx_packetizer

Packet-to-flit transmitter for the network-interface side of a router input port. It accepts a packet descriptor plus a stream of payload words and serializes them into head, body and tail flits tagged with a virtual-channel id. The flits are driven on the same `s_flit_req_t` / `s_flit_resp_t` valid/ready interface that a router input datapath consumes. It is the sending end of that interface: one packet in flight, wormhole order preserved, no interleaving of VCs within a packet.

## Interface
- `MAX_PKT_FLITS`, default 256: maximum number of body/tail flits per packet; must be ≤ 2^PKT_WIDTH − 1.
- `clk`  in  1  clock; all logic is on its rising edge.
- `arst`  in  1  asynchronous, active-low reset.
- `pkt_valid_i`  in  1  packet descriptor valid.
- `pkt_ready_o`  out  1  descriptor accepted when high together with valid.
- `pkt_vc_i`  in  VC_WIDTH  target virtual channel.
- `pkt_x_i`  in  X_WIDTH  destination column.
- `pkt_y_i`  in  Y_WIDTH  destination row.
- `pkt_size_i`  in  PKT_WIDTH  number of payload flits following the head (0 = head-only packet).
- `data_valid_i`  in  1  payload word valid.
- `data_ready_o`  out  1  payload word consumed.
- `data_i`  in  FLIT_DATA_WIDTH  payload word.
- `fout_req_o`  out  s_flit_req_t  flit output: `fdata`, `valid`, `vc_id`.
- `fout_resp_i`  in  s_flit_resp_t  `ready` from the downstream input datapath.
- `busy_o`  out  1  a packet is in progress (state ≠ IDLE or output register occupied).

## Operation
- Flit type occupies `fdata[FLIT_WIDTH-1 -: 2]`:
  - HEAD = 2'b01
  - BODY = 2'b10
  - TAIL = 2'b11
- Head flit fields below the type: `x_dest`, `y_dest`, `pkt_size`; remaining bits are zero.
- Body and tail flits: type, then `data_i` in the low FLIT_DATA_WIDTH bits.
- FSM states:
  - IDLE: `pkt_ready_o` = 1 if the output register is empty or is being drained this cycle. On a descriptor handshake, latch vc/x/y/size, load the head flit into the output register, and go to PAYLOAD (or back to IDLE if size = 0).
  - PAYLOAD: `data_ready_o` = `data_valid_i`-independent (output empty or draining). Each data handshake loads a flit and decrements `remaining`. The flit is BODY while `remaining` > 1 and TAIL when `remaining` = 1; the tail handshake returns the FSM to IDLE.
- `remaining` is PKT_WIDTH wide and never wraps; it is loaded with `pkt_size_i` and only decremented in PAYLOAD.
- `vc_id` is constant for the whole packet; it changes only on the head flit.
- Descriptor sizes above MAX_PKT_FLITS are clamped to MAX_PKT_FLITS.

## Timing
- Output is a single register stage: `fout_req_o.valid` holds with stable `fdata`/`vc_id` until `fout_resp_i.ready` is high.
- Load and drain may happen in the same cycle, so full throughput is one flit per cycle with `ready` held high.
- Latency: descriptor handshake in cycle N → head valid in cycle N+1; data handshake in cycle M → flit valid in cycle M+1.
- Back-to-back packets: the next descriptor may be accepted in the same cycle the tail drains, so there are no bubbles.
- Reset values:
  - `fout_req_o` = '0
  - `pkt_ready_o` = 1
  - `data_ready_o` = 0
  - `busy_o` = 0
  - FSM = IDLE, `remaining` = 0
- Reset mid-packet drops the partial packet immediately; no tail is emitted.
- `data_valid_i` in IDLE is ignored (`data_ready_o` = 0).
- `pkt_valid_i` in PAYLOAD is ignored (`pkt_ready_o` = 0).

## Configuration
- `RAVENOC_TX_STATS_EN` defined:
  - adds outputs `stat_pkts_o` [31:0] (incremented on each tail or head-only handshake out) and `stat_stall_o` [31:0] (incremented each cycle with valid high and ready low);
  - both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Not defined: those ports and counters do not exist; behaviour is otherwise identical.

## Structure
- `ravenoc_pkg` holds:
  - flit type enum `flit_type_t`
  - head-flit struct `s_flit_head_data_t`
  - FLIT_WIDTH, FLIT_DATA_WIDTH, PKT_WIDTH, X_WIDTH, Y_WIDTH, VC_WIDTH
  - existing `s_flit_req_t` / `s_flit_resp_t`
- Sub-module `flit_out_reg`: one-entry valid/ready pipeline register with simultaneous load/drain. FSM and counters stay in the top level.

## Test plan
- Packet vc=1, x=2, y=3, size=2, data 0xA, 0xB, ready always 1 → flits HEAD(x2, y3, size 2), BODY 0xA, TAIL 0xB on consecutive cycles, all with vc_id=1.
- size=0, vc=0 → one HEAD flit with size 0; `pkt_ready_o` high again the next cycle; no data consumed.
- Same packet as the first scenario with ready low for 3 cycles on the head → head held stable 4 cycles, `data_ready_o` low during the stall, and `stat_stall_o` = 3 when stats are enabled.
- Two packets back to back (vc 2 size 1, then vc 0 size 1) with ready high → 4 flits in 4 consecutive cycles, with vc_id switching on the second head.
- Assert `arst` low after the BODY of a size-3 packet → valid drops at once, FSM IDLE, and the next packet starts with a clean HEAD.
- size=MAX_PKT_FLITS+5 → exactly MAX_PKT_FLITS payload flits sent and the last is a TAIL.
